collision_scanner: RTL

COLLISION_SCANNER -- requirements
Module: collision_scanner

---
 rtl/collision_scanner_pkg.sv | 38 +++
 rtl/collision_scanner_box_overlap.sv | 30 +++
 rtl/collision_scanner.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_scanner_pkg.sv
// ---------------------------------------------------------------------------
// collision_scanner_pkg
// Shared definitions for the collision scanner: entity word layout, default
// slot counts and overlap radii, coordinate/distance widths and the scan FSM
// state encoding.
// ---------------------------------------------------------------------------
package collision_scanner_pkg;

    // Entity word layout
    localparam int ENTITY_SIZE   = 34;
    localparam int DIR_LSB       = 0;
    localparam int DIR_MSB       = 5;
    localparam int X_LSB         = 6;
    localparam int X_MSB         = 15;
    localparam int Y_LSB         = 16;
    localparam int Y_MSB         = 25;
    localparam int RSV_LSB       = 26;
    localparam int RSV_MSB       = 32;
    localparam int ACTIVE_BIT    = 33;

    localparam int COORD_W       = X_MSB - X_LSB + 1;   // 10-bit screen coordinate
    localparam int DIST_W        = COORD_W + 1;         // 11-bit absolute difference

    // Slot counts and overlap half-widths
    localparam int MAX_SHOTS     = 3;
    localparam int MAX_ASTEROIDS = 4;
    localparam int HIT_RADIUS    = 8;
    localparam int SHIP_RADIUS   = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SNAP      = 3'd1,
        ST_SCAN_SA   = 3'd2,
        ST_SCAN_SHIP = 3'd3,
        ST_FINISH    = 3'd4
    } scan_state_e;

endpackage

// File: rtl/collision_scanner_box_overlap.sv
// ---------------------------------------------------------------------------
// box_overlap
// Purely combinational square-box overlap test between two points.
//   a_x, a_y  : first entity coordinates
//   b_x, b_y  : second entity coordinates
//   radius    : half-width of the box, in pixels
//   hit       : 1 when |a_x-b_x| < radius and |a_y-b_y| < radius
// Distances are plain absolute differences; the screen does not wrap.
// ---------------------------------------------------------------------------
module box_overlap
    import collision_scanner_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [DIST_W-1:0]  radius,
    output logic               hit
);

    logic [DIST_W-1:0] dx;
    logic [DIST_W-1:0] dy;

    always_comb begin
        dx  = (a_x >= b_x) ? (DIST_W'(a_x) - DIST_W'(b_x)) : (DIST_W'(b_x) - DIST_W'(a_x));
        dy  = (a_y >= b_y) ? (DIST_W'(a_y) - DIST_W'(b_y)) : (DIST_W'(b_y) - DIST_W'(a_y));
        hit = (dx < radius) && (dy < radius);
    end

endmodule

// File: rtl/collision_scanner.sv
// ---------------------------------------------------------------------------
// collision_scanner
// On a start pulse, snapshots the ship, shot and asteroid entity words, then
// walks every (shot, asteroid) pair followed by every (ship, asteroid) pair,
// one pair per cycle, issuing registered delete / hit pulses for overlaps.
//
// Ports
//   move_clk          scan clock
//   reset_n           synchronous active-low reset
//   start             one-cycle scan request (ignored while busy)
//   ship              ship entity word
//   shots             packed shot entity words, slot 0 in the LSBs
//   asteroids         packed asteroid entity words, slot 0 in the LSBs
//   delete_shot       pulse: delete shot slot shot_address
//   shot_address      shot slot index, holds between pulses
//   delete_asteroid   pulse: delete asteroid slot asteroid_address
//   asteroid_address  asteroid slot index, holds between pulses
//   ship_hit          pulse: ship overlapped an active asteroid
//   busy              scan in progress (through the done cycle)
//   done              pulse at scan completion
//
// States
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_IDLE      | waiting for start
//   ST_SNAP      | capture entity inputs into snapshot registers
//   ST_SCAN_SA   | test shot i against asteroid j, j innermost
//   ST_SCAN_SHIP | test ship against asteroid j
//   ST_FINISH    | done pulse visible, return to idle
// ---------------------------------------------------------------------------
module collision_scanner #(
    parameter  int ENTITY_SIZE   = collision_scanner_pkg::ENTITY_SIZE,
    parameter  int MAX_SHOTS     = collision_scanner_pkg::MAX_SHOTS,
    parameter  int MAX_ASTEROIDS = collision_scanner_pkg::MAX_ASTEROIDS,
    parameter  int HIT_RADIUS    = collision_scanner_pkg::HIT_RADIUS,
    parameter  int SHIP_RADIUS   = collision_scanner_pkg::SHIP_RADIUS,
    localparam int SHOT_AW       = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1,
    localparam int AST_AW        = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1
) (
    input  logic                                 move_clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [ENTITY_SIZE-1:0]               ship,
    input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
    input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
    output logic                                 delete_shot,
    output logic [SHOT_AW-1:0]                   shot_address,
    output logic                                 delete_asteroid,
    output logic [AST_AW-1:0]                    asteroid_address,
    output logic                                 ship_hit,
    output logic                                 busy,
    output logic                                 done
);

    import collision_scanner_pkg::*;

    localparam logic [SHOT_AW-1:0] SHOT_LAST = SHOT_AW'(MAX_SHOTS - 1);
    localparam logic [AST_AW-1:0]  AST_LAST  = AST_AW'(MAX_ASTEROIDS - 1);

    // FSM and loop indices
    scan_state_e state_q, state_d;
    logic [SHOT_AW-1:0] i_q, i_d;
    logic [AST_AW-1:0]  j_q, j_d;

    // Snapshot registers: only active bit and coordinates are kept
    logic                                   ship_act_q, ship_act_d;
    logic [COORD_W-1:0]                     ship_x_q, ship_x_d;
    logic [COORD_W-1:0]                     ship_y_q, ship_y_d;
    logic [MAX_SHOTS-1:0]                   shot_act_q, shot_act_d;
    logic [MAX_SHOTS-1:0][COORD_W-1:0]      shot_x_q, shot_x_d;
    logic [MAX_SHOTS-1:0][COORD_W-1:0]      shot_y_q, shot_y_d;
    logic [MAX_ASTEROIDS-1:0]               ast_act_q, ast_act_d;
    logic [MAX_ASTEROIDS-1:0][COORD_W-1:0]  ast_x_q, ast_x_d;
    logic [MAX_ASTEROIDS-1:0][COORD_W-1:0]  ast_y_q, ast_y_d;

    // Registered outputs
    logic               delete_shot_q, delete_shot_d;
    logic [SHOT_AW-1:0] shot_address_q, shot_address_d;
    logic               delete_asteroid_q, delete_asteroid_d;
    logic [AST_AW-1:0]  asteroid_address_q, asteroid_address_d;
    logic               ship_hit_q, ship_hit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Shared overlap checker operands
    logic [COORD_W-1:0] ovl_ax, ovl_ay, ovl_bx, ovl_by;
    logic [DIST_W-1:0]  ovl_radius;
    logic               ovl_hit;
    logic               a_act, b_act, pair_hit;

    // Direction and reserved fields play no part in collisions.
    logic unused_fields;
    assign unused_fields = ^{ship, shots, asteroids};

    // The left operand is the shot during SCAN_SA and the ship during
    // SCAN_SHIP; the right operand is always asteroid j.
    always_comb begin
        ovl_ax     = shot_x_q[i_q];
        ovl_ay     = shot_y_q[i_q];
        a_act      = shot_act_q[i_q];
        ovl_radius = DIST_W'(HIT_RADIUS);
        if (state_q == ST_SCAN_SHIP) begin
            ovl_ax     = ship_x_q;
            ovl_ay     = ship_y_q;
            a_act      = ship_act_q;
            ovl_radius = DIST_W'(SHIP_RADIUS);
        end
        ovl_bx   = ast_x_q[j_q];
        ovl_by   = ast_y_q[j_q];
        b_act    = ast_act_q[j_q];
        pair_hit = ovl_hit & a_act & b_act;
    end

    box_overlap u_box_overlap (
        .a_x    (ovl_ax),
        .a_y    (ovl_ay),
        .b_x    (ovl_bx),
        .b_y    (ovl_by),
        .radius (ovl_radius),
        .hit    (ovl_hit)
    );

    always_comb begin
        state_d            = state_q;
        i_d                = i_q;
        j_d                = j_q;
        ship_act_d         = ship_act_q;
        ship_x_d           = ship_x_q;
        ship_y_d           = ship_y_q;
        shot_act_d         = shot_act_q;
        shot_x_d           = shot_x_q;
        shot_y_d           = shot_y_q;
        ast_act_d          = ast_act_q;
        ast_x_d            = ast_x_q;
        ast_y_d            = ast_y_q;
        delete_shot_d      = 1'b0;
        delete_asteroid_d  = 1'b0;
        ship_hit_d         = 1'b0;
        done_d             = 1'b0;
        shot_address_d     = shot_address_q;
        asteroid_address_d = asteroid_address_q;
        busy_d             = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SNAP;
                    busy_d  = 1'b1;
                end
            end

            ST_SNAP: begin
                ship_act_d = ship[ACTIVE_BIT];
                ship_x_d   = ship[X_MSB:X_LSB];
                ship_y_d   = ship[Y_MSB:Y_LSB];
                for (int s = 0; s < MAX_SHOTS; s++) begin
                    shot_act_d[s] = shots[s*ENTITY_SIZE + ACTIVE_BIT];
                    shot_x_d[s]   = shots[s*ENTITY_SIZE + X_LSB +: COORD_W];
                    shot_y_d[s]   = shots[s*ENTITY_SIZE + Y_LSB +: COORD_W];
                end
                for (int a = 0; a < MAX_ASTEROIDS; a++) begin
                    ast_act_d[a] = asteroids[a*ENTITY_SIZE + ACTIVE_BIT];
                    ast_x_d[a]   = asteroids[a*ENTITY_SIZE + X_LSB +: COORD_W];
                    ast_y_d[a]   = asteroids[a*ENTITY_SIZE + Y_LSB +: COORD_W];
                end
                i_d     = '0;
                j_d     = '0;
                state_d = ST_SCAN_SA;
            end

            ST_SCAN_SA: begin
                // Clearing both snapshot bits stops this shot from taking out
                // a higher-index asteroid and this asteroid from being
                // deleted again by a later shot.
                if (pair_hit) begin
                    delete_shot_d      = 1'b1;
                    delete_asteroid_d  = 1'b1;
                    shot_address_d     = i_q;
                    asteroid_address_d = j_q;
                    shot_act_d[i_q]    = 1'b0;
                    ast_act_d[j_q]     = 1'b0;
                end
                if (j_q == AST_LAST) begin
                    j_d = '0;
                    if (i_q == SHOT_LAST) begin
                        i_d     = '0;
                        state_d = ST_SCAN_SHIP;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            ST_SCAN_SHIP: begin
                if (pair_hit) begin
                    ship_hit_d         = 1'b1;
                    delete_asteroid_d  = 1'b1;
                    asteroid_address_d = j_q;
                    ast_act_d[j_q]     = 1'b0;
                end
                if (j_q == AST_LAST) begin
                    j_d     = '0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge move_clk) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            i_q                <= '0;
            j_q                <= '0;
            ship_act_q         <= 1'b0;
            ship_x_q           <= '0;
            ship_y_q           <= '0;
            shot_act_q         <= '0;
            shot_x_q           <= '0;
            shot_y_q           <= '0;
            ast_act_q          <= '0;
            ast_x_q            <= '0;
            ast_y_q            <= '0;
            delete_shot_q      <= 1'b0;
            shot_address_q     <= '0;
            delete_asteroid_q  <= 1'b0;
            asteroid_address_q <= '0;
            ship_hit_q         <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            i_q                <= i_d;
            j_q                <= j_d;
            ship_act_q         <= ship_act_d;
            ship_x_q           <= ship_x_d;
            ship_y_q           <= ship_y_d;
            shot_act_q         <= shot_act_d;
            shot_x_q           <= shot_x_d;
            shot_y_q           <= shot_y_d;
            ast_act_q          <= ast_act_d;
            ast_x_q            <= ast_x_d;
            ast_y_q            <= ast_y_d;
            delete_shot_q      <= delete_shot_d;
            shot_address_q     <= shot_address_d;
            delete_asteroid_q  <= delete_asteroid_d;
            asteroid_address_q <= asteroid_address_d;
            ship_hit_q         <= ship_hit_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
        end
    end

    assign delete_shot      = delete_shot_q;
    assign shot_address     = shot_address_q;
    assign delete_asteroid  = delete_asteroid_q;
    assign asteroid_address = asteroid_address_q;
    assign ship_hit         = ship_hit_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
